thermo_encoder_pipe: RTL



---
 rtl/thermo_encoder_pipe.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/thermo_encoder_pipe.sv
// Pipelined thermometer-to-binary encoder for the TDC fine-time path, with bubble/overflow
// flags and a saturating bubble counter. Define THERMO_BUBBLE_FILTER_EN to enable the 3-tap majority filter.

// Per-segment transition search: leading-ones count and "one after the first zero" flag.
module thermo_seg (
    input  logic [7:0] seg,
    output logic       all_ones,
    output logic [3:0] lead,
    output logic       bub
);
    logic zero_seen;

    assign all_ones = &seg;

    always_comb begin
        lead      = '0;
        bub       = 1'b0;
        zero_seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (!zero_seen) begin
                if (seg[i]) lead = lead + 4'd1;
                else        zero_seen = 1'b1;
            end else if (seg[i]) begin
                bub = 1'b1;
            end
        end
    end
endmodule

module thermo_encoder_pipe #(
    parameter int THERMO_W = 63,
    parameter int BIN_W    = 6,
    parameter int ERRCNT_W = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    input  logic [THERMO_W-1:0] thermo,
    input  logic                cnt_clr,
    output logic                out_valid,
    output logic [BIN_W-1:0]    bin,
    output logic                bubble_err,
    output logic                ovf,
    output logic [ERRCNT_W-1:0] err_cnt
);
    localparam int NSEG   = (THERMO_W + 7) / 8;
    localparam int PAD_W  = NSEG * 8;
    localparam int STAGES = 3;

    if (THERMO_W < 3) begin : g_chk_w
        $error("thermo_encoder_pipe: THERMO_W must be >= 3");
    end
    if ((2 ** BIN_W) <= THERMO_W) begin : g_chk_bin
        $error("thermo_encoder_pipe: 2**BIN_W must exceed THERMO_W");
    end

    // vld_pipe[0]: t1, [1]: segment regs, [2]: merge regs, [3]: output regs
    logic [STAGES:0] vld_pipe;

    always_ff @(posedge clk) begin
        if (rst) vld_pipe <= '0;
        else     vld_pipe <= {vld_pipe[STAGES-1:0], in_valid};
    end

    // S1: input register and optional bubble filter
    logic [THERMO_W-1:0] t1;
    logic [THERMO_W-1:0] f;
    logic [PAD_W-1:0]    fpad;

    always_ff @(posedge clk) begin
        if (in_valid) t1 <= thermo;
    end

`ifdef THERMO_BUBBLE_FILTER_EN
    // Virtual taps: a 1 below bit 0 and a 0 above the top tap.
    logic [THERMO_W+1:0] ext;
    assign ext = {1'b0, t1, 1'b1};
    for (genvar i = 0; i < THERMO_W; i++) begin : g_filt
        assign f[i] = (ext[i] & ext[i+1]) | (ext[i] & ext[i+2]) | (ext[i+1] & ext[i+2]);
    end
`else
    assign f = t1;
`endif

    assign fpad = PAD_W'(f);

    // S2: per-segment search, registered
    logic [NSEG-1:0]      seg_all_c, seg_bub_c;
    logic [NSEG-1:0][3:0] seg_lead_c;
    logic [NSEG-1:0]      seg_all, seg_bub;
    logic [NSEG-1:0][3:0] seg_lead;

    for (genvar s = 0; s < NSEG; s++) begin : g_seg
        thermo_seg u_seg (
            .seg      (fpad[s*8 +: 8]),
            .all_ones (seg_all_c[s]),
            .lead     (seg_lead_c[s]),
            .bub      (seg_bub_c[s])
        );
    end

    always_ff @(posedge clk) begin
        if (vld_pipe[0]) begin
            seg_all  <= seg_all_c;
            seg_lead <= seg_lead_c;
            seg_bub  <= seg_bub_c;
        end
    end

    // S3: merge. Segments add up until the first one that is not all ones;
    // any set bit in a later segment is a bubble.
    logic [BIN_W-1:0] m_bin_c;
    logic             m_bub_c;
    logic             m_ovf_c;
    logic             found;

    always_comb begin
        m_bin_c = '0;
        m_bub_c = 1'b0;
        found   = 1'b0;
        for (int k = 0; k < NSEG; k++) begin
            if (!found) begin
                m_bin_c = m_bin_c + BIN_W'(seg_lead[k]);
                if (!seg_all[k]) begin
                    found   = 1'b1;
                    m_bub_c = seg_bub[k];
                end
            end else if (seg_lead[k] != 4'd0 || seg_bub[k]) begin
                m_bub_c = 1'b1;
            end
        end
        m_ovf_c = (m_bin_c == BIN_W'(THERMO_W));
    end

    logic [BIN_W-1:0] m_bin;
    logic             m_bub;
    logic             m_ovf;

    always_ff @(posedge clk) begin
        if (vld_pipe[1]) begin
            m_bin <= m_bin_c;
            m_bub <= m_bub_c;
            m_ovf <= m_ovf_c;
        end
    end

    // Output registers hold their value between valid samples.
    always_ff @(posedge clk) begin
        if (rst) begin
            bin        <= '0;
            bubble_err <= 1'b0;
            ovf        <= 1'b0;
        end else if (vld_pipe[2]) begin
            bin        <= m_bin;
            bubble_err <= m_bub;
            ovf        <= m_ovf;
        end
    end

    assign out_valid = vld_pipe[STAGES];

    always_ff @(posedge clk) begin
        if (rst)
            err_cnt <= '0;
        else if (cnt_clr)
            err_cnt <= '0;
        else if (out_valid && bubble_err && err_cnt != {ERRCNT_W{1'b1}})
            err_cnt <= err_cnt + ERRCNT_W'(1);
    end
endmodule
